mm_bus: RTL and testbench

- Memory-stage unit for the 5-stage MIPS core that replaces the single-cycle SRAM access with a multi-cycle ready-based bus transaction.
- Generates per-byte write enables instead of replicated store data, stalls the pipeline until the bus completes, and formats load results: LB/LBU/LH/LHU/LW/LWL/LWR.
- Sits between ex and wb; the data output also feeds the bypass mux.

---
 rtl/mm_bus_pkg.sv | 39 +++
 rtl/mm_bus_if.sv | 25 ++
 rtl/mm_lane_align.sv | 62 ++++++
 rtl/mm_bus.sv | 164 ++++++++++++++++
 tb/tb_mm_bus.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_bus_pkg.sv
// Shared definitions for the mm_bus memory stage: access encodings, FSM states,
// lane payload struct and the alignment rule.
package mm_bus_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned TIMER_W = 16;

    localparam logic [TYPE_W-1:0] MEM_ACCESS_TYPE_NONE = 2'd0;
    localparam logic [TYPE_W-1:0] MEM_ACCESS_TYPE_M2R  = 2'd1;
    localparam logic [TYPE_W-1:0] MEM_ACCESS_TYPE_R2M  = 2'd2;

    localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_BYTE       = 3'd0;
    localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_HALF       = 3'd1;
    localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_WORD       = 3'd2;
    localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_LEFT_WORD  = 3'd3;
    localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_RIGHT_WORD = 3'd4;

    typedef enum logic [1:0] {
        MM_BUS_ST_IDLE   = 2'd0,
        MM_BUS_ST_ACCESS = 2'd1,
        MM_BUS_ST_DONE   = 2'd2
    } mm_bus_state_e;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } lane_store_t;

    // HALF needs 2-byte alignment, WORD 4-byte; LWL/LWR/byte never fault
    function automatic logic misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] offs);
        return ((size == MEM_ACCESS_LENGTH_HALF) && offs[0]) ||
               ((size == MEM_ACCESS_LENGTH_WORD) && (offs != 2'b00));
    endfunction

endpackage

// File: rtl/mm_bus_if.sv
// Ready-based memory bus between the mm stage (master) and memory (slave).
interface mm_bus_if
    import mm_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [BE_W-1:0]   bus_be_o;
    logic              bus_rd_o;
    logic              bus_wr_o;
    logic              bus_err_o;
    logic              bus_ready_i;
    logic [DATA_W-1:0] bus_rdata_i;

    modport master (
        output bus_addr_o, bus_wdata_o, bus_be_o, bus_rd_o, bus_wr_o, bus_err_o,
        input  bus_ready_i, bus_rdata_i
    );

    modport slave (
        input  bus_addr_o, bus_wdata_o, bus_be_o, bus_rd_o, bus_wr_o, bus_err_o,
        output bus_ready_i, bus_rdata_i
    );
endinterface

// File: rtl/mm_lane_align.sv
// Combinational byte-lane steering: store byte enables/data placement and
// load extraction, sign extension and LWL/LWR merge with the old rt value.
module mm_lane_align
    import mm_bus_pkg::*;
(
    input  logic [SIZE_W-1:0] size,
    input  logic [1:0]        offs,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] rdata,
    output lane_store_t       store,
    output logic [DATA_W-1:0] load_data
);
    logic [4:0]  sh_lo;
    logic [4:0]  sh_hi;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign sh_lo  = {offs, 3'b000};
    assign sh_hi  = {~offs, 3'b000};
    assign lane_b = 8'(rdata >> sh_lo);
    assign lane_h = offs[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        store.be    = '0;
        store.wdata = '0;
        load_data   = '0;
        case (size)
            MEM_ACCESS_LENGTH_BYTE: begin
                store.be    = 4'b0001 << offs;
                store.wdata = data << sh_lo;
                load_data   = sign_ext ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
            end
            MEM_ACCESS_LENGTH_HALF: begin
                store.be    = offs[1] ? 4'b1100 : 4'b0011;
                store.wdata = data << {offs[1], 4'b0000};
                load_data   = sign_ext ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
            end
            MEM_ACCESS_LENGTH_WORD: begin
                store.be    = 4'b1111;
                store.wdata = data;
                load_data   = rdata;
            end
            // unaligned pair: memory bytes fill the high (LWL) or low (LWR) end of rt
            MEM_ACCESS_LENGTH_LEFT_WORD: begin
                store.be    = 4'b1111 >> ~offs;
                store.wdata = data >> sh_hi;
                load_data   = (rdata << sh_hi) | (data & ~(32'hFFFF_FFFF << sh_hi));
            end
            MEM_ACCESS_LENGTH_RIGHT_WORD: begin
                store.be    = 4'b1111 << offs;
                store.wdata = data << sh_lo;
                load_data   = (rdata >> sh_lo) | (data & ~(32'hFFFF_FFFF >> sh_lo));
            end
            default: begin
                store.be    = '0;
                store.wdata = '0;
                load_data   = '0;
            end
        endcase
    end
endmodule

// File: rtl/mm_bus.sv
// MIPS memory stage driving a multi-cycle ready-based bus; stalls ex/mm until done.
// Optional MM_BUS_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYCLES and pulses bus_err_o.
module mm_bus
    import mm_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TYPE_W-1:0]  mem_access_type,
    input  logic [SIZE_W-1:0]  mem_access_size,
    input  logic               mem_access_signed,
    input  logic [ADDR_W-1:0]  mem_access_addr_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [REG_W-1:0]   reg_addr_i,
    mm_bus_if.master           bus,
    output logic [DATA_W-1:0]  data_o,
    output logic [REG_W-1:0]   bypass_reg_addr_mm,
    output logic               stall_o,
    output logic               alignment_err
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mm_bus: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic                is_load, is_store, req, timeout;
    mm_bus_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, result_q, result_d, lane_load;
    logic [BE_W-1:0]     be_q, be_d;
    logic                rd_q, rd_d, wr_q, wr_d, sign_q, sign_d, load_q, load_d;
    logic [SIZE_W-1:0]   size_q, size_d, lane_size;
    logic [1:0]          offs_q, offs_d, lane_offs;
    logic                lane_sign;
    lane_store_t         lane_store;

    assign is_load       = (mem_access_type == MEM_ACCESS_TYPE_M2R);
    assign is_store      = (mem_access_type == MEM_ACCESS_TYPE_R2M);
    assign alignment_err = (is_load | is_store) & misaligned(mem_access_size, mem_access_addr_i[1:0]);
    assign req           = (is_load | is_store) & ~alignment_err;

    // Live controls shape store lanes in IDLE; the captured ones shape the load result
    assign lane_size = (state_q == MM_BUS_ST_IDLE) ? mem_access_size : size_q;
    assign lane_offs = (state_q == MM_BUS_ST_IDLE) ? mem_access_addr_i[1:0] : offs_q;
    assign lane_sign = (state_q == MM_BUS_ST_IDLE) ? mem_access_signed : sign_q;

    mm_lane_align u_lane (
        .size      (lane_size),
        .offs      (lane_offs),
        .sign_ext  (lane_sign),
        .data      (data_i),
        .rdata     (bus.bus_rdata_i),
        .store     (lane_store),
        .load_data (lane_load)
    );

`ifdef MM_BUS_TIMEOUT_EN
    logic [TIMER_W-1:0] timer_q;
    logic               err_q;

    assign timeout       = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign bus.bus_err_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (state_q == MM_BUS_ST_ACCESS) && !bus.bus_ready_i && timeout;
            if (state_q == MM_BUS_ST_ACCESS) timer_q <= timer_q + TIMER_W'(1);
            else                             timer_q <= '0;
        end
    end
`else
    assign timeout       = 1'b0;
    assign bus.bus_err_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        result_d = result_q;
        size_d   = size_q;
        offs_d   = offs_q;
        sign_d   = sign_q;
        load_d   = load_q;
        unique case (state_q)
            MM_BUS_ST_IDLE: begin
                if (req) begin
                    state_d = MM_BUS_ST_ACCESS;
                    addr_d  = {mem_access_addr_i[ADDR_W-1:2], 2'b00};
                    be_d    = is_store ? lane_store.be : '0;
                    wdata_d = is_store ? lane_store.wdata : '0;
                    rd_d    = is_load;
                    wr_d    = is_store;
                    size_d  = mem_access_size;
                    offs_d  = mem_access_addr_i[1:0];
                    sign_d  = mem_access_signed;
                    load_d  = is_load;
                end
            end
            MM_BUS_ST_ACCESS: begin
                if (bus.bus_ready_i) begin
                    state_d  = MM_BUS_ST_DONE;
                    result_d = lane_load;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    be_d     = '0;
                end else if (timeout) begin
                    state_d  = MM_BUS_ST_DONE;
                    result_d = '0;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    be_d     = '0;
                end
            end
            MM_BUS_ST_DONE: state_d = MM_BUS_ST_IDLE;
            default:        state_d = MM_BUS_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MM_BUS_ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            result_q <= '0;
            size_q   <= '0;
            offs_q   <= '0;
            sign_q   <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            result_q <= result_d;
            size_q   <= size_d;
            offs_q   <= offs_d;
            sign_q   <= sign_d;
            load_q   <= load_d;
        end
    end

    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign bus.bus_be_o    = be_q;
    assign bus.bus_rd_o    = rd_q;
    assign bus.bus_wr_o    = wr_q;

    assign stall_o            = (state_q == MM_BUS_ST_ACCESS) | ((state_q == MM_BUS_ST_IDLE) & req);
    assign data_o             = ((state_q == MM_BUS_ST_DONE) && load_q) ? result_q : data_i;
    assign bypass_reg_addr_mm = reg_addr_i;
endmodule

// File: tb/tb_mm_bus.sv
// Self-checking bench for mm_bus: directed scenarios plus random transactions
// against a byte-level reference model of MIPS load/store lane behaviour.
module tb_mm_bus;
    import mm_bus_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  mem_access_type = MEM_ACCESS_TYPE_NONE;
    logic [2:0]  mem_access_size = '0;
    logic        mem_access_signed = 1'b0;
    logic [31:0] mem_access_addr_i = '0;
    logic [31:0] data_i = '0;
    logic [4:0]  reg_addr_i = '0;
    logic [31:0] data_o;
    logic [4:0]  bypass_reg_addr_mm;
    logic        stall_o, alignment_err;

    int checks = 0;
    int errors = 0;

    mm_bus_if #(.ADDR_W(32)) bus_if ();

    mm_bus #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_access_type    (mem_access_type),
        .mem_access_size    (mem_access_size),
        .mem_access_signed  (mem_access_signed),
        .mem_access_addr_i  (mem_access_addr_i),
        .data_i             (data_i),
        .reg_addr_i         (reg_addr_i),
        .bus                (bus_if.master),
        .data_o             (data_o),
        .bypass_reg_addr_mm (bypass_reg_addr_mm),
        .stall_o            (stall_o),
        .alignment_err      (alignment_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (byte granular) ----------------
    function automatic logic m_misaligned(input logic [2:0] sz, input logic [1:0] a);
        if (sz == MEM_ACCESS_LENGTH_HALF) return a[0];
        if (sz == MEM_ACCESS_LENGTH_WORD) return a != 2'b00;
        return 1'b0;
    endfunction

    task automatic m_store(input logic [2:0] sz, input logic [1:0] a, input logic [31:0] din,
                           output logic [3:0] be, output logic [31:0] wd);
        logic [7:0] d [4];
        int ai, h;
        ai = int'(a);
        for (int i = 0; i < 4; i++) d[i] = din[8*i +: 8];
        be = '0; wd = '0;
        case (sz)
            MEM_ACCESS_LENGTH_BYTE: begin be[ai] = 1'b1; wd[8*ai +: 8] = d[0]; end
            MEM_ACCESS_LENGTH_HALF: begin
                h = (ai / 2) * 2;
                be[h] = 1'b1; be[h+1] = 1'b1;
                wd[8*h +: 8] = d[0]; wd[8*(h+1) +: 8] = d[1];
            end
            MEM_ACCESS_LENGTH_WORD: begin be = 4'hF; wd = din; end
            MEM_ACCESS_LENGTH_LEFT_WORD:
                for (int i = 0; i <= ai; i++) begin be[i] = 1'b1; wd[8*i +: 8] = d[i + 3 - ai]; end
            MEM_ACCESS_LENGTH_RIGHT_WORD:
                for (int i = ai; i < 4; i++) begin be[i] = 1'b1; wd[8*i +: 8] = d[i - ai]; end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic sg, input logic [1:0] a,
                                           input logic [31:0] rdata, input logic [31:0] old);
        logic [7:0]  r [4];
        logic [7:0]  b;
        logic [15:0] hw;
        logic [31:0] res;
        int ai, h;
        ai = int'(a);
        for (int i = 0; i < 4; i++) r[i] = rdata[8*i +: 8];
        res = '0;
        case (sz)
            MEM_ACCESS_LENGTH_BYTE: begin
                b = r[ai];
                res = sg ? {{24{b[7]}}, b} : {24'h0, b};
            end
            MEM_ACCESS_LENGTH_HALF: begin
                h = (ai / 2) * 2;
                hw = {r[h+1], r[h]};
                res = sg ? {{16{hw[15]}}, hw} : {16'h0, hw};
            end
            MEM_ACCESS_LENGTH_WORD: res = rdata;
            MEM_ACCESS_LENGTH_LEFT_WORD:
                for (int i = 0; i < 4; i++)
                    res[8*i +: 8] = (i >= 3 - ai) ? r[i - (3 - ai)] : old[8*i +: 8];
            MEM_ACCESS_LENGTH_RIGHT_WORD:
                for (int i = 0; i < 4; i++)
                    res[8*i +: 8] = (i <= 3 - ai) ? r[i + ai] : old[8*i +: 8];
            default: res = '0;
        endcase
        return res;
    endfunction

    // ---------------- driver: one pipeline op, observes bus and result ----------------
    task automatic run_txn(input logic [1:0] ty, input logic [2:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] din, input int wait_n,
                           input logic [31:0] rdata,
                           output int stalls, output logic aerr, output logic [31:0] dout,
                           output logic [31:0] baddr, output logic [3:0] be, output logic [31:0] wd,
                           output logic rd, output logic wr, output logic stable);
        logic [69:0] snap;
        mem_access_type = ty; mem_access_size = sz; mem_access_signed = sg;
        mem_access_addr_i = ad; data_i = din; reg_addr_i = 5'($urandom);
        bus_if.bus_ready_i = 1'b0; bus_if.bus_rdata_i = $urandom;
        stalls = 0; baddr = '0; be = '0; wd = '0; rd = 1'b0; wr = 1'b0; stable = 1'b1; snap = '0;
        @(negedge clk);
        aerr = alignment_err;
        while (stall_o === 1'b1 && stalls < 300) begin
            stalls++;
            if (stalls == 2) begin
                baddr = bus_if.bus_addr_o; be = bus_if.bus_be_o; wd = bus_if.bus_wdata_o;
                rd = bus_if.bus_rd_o; wr = bus_if.bus_wr_o;
                snap = {baddr, wd, be, rd, wr};
            end else if (stalls > 2 && {bus_if.bus_addr_o, bus_if.bus_wdata_o, bus_if.bus_be_o,
                                        bus_if.bus_rd_o, bus_if.bus_wr_o} !== snap) begin
                stable = 1'b0;
            end
            @(posedge clk); #1;
            bus_if.bus_ready_i = (stalls - 1 == wait_n);
            bus_if.bus_rdata_i = bus_if.bus_ready_i ? rdata : $urandom;
            @(negedge clk);
        end
        dout = data_o;
        @(posedge clk); #1;
        mem_access_type = MEM_ACCESS_TYPE_NONE;
        bus_if.bus_ready_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] din;
        din = 32'h1234_5678;
        data_i = din; reg_addr_i = 5'd17; mem_access_type = MEM_ACCESS_TYPE_NONE;
        bus_if.bus_ready_i = 1'b0; bus_if.bus_rdata_i = '0;
        #2 rst_n = 1'b0;
        #6;
        checks++;
        if ({bus_if.bus_rd_o, bus_if.bus_wr_o, bus_if.bus_be_o, bus_if.bus_err_o} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got rd=%b wr=%b be=%b err=%b want 0", bus_if.bus_rd_o,
                               bus_if.bus_wr_o, bus_if.bus_be_o, bus_if.bus_err_o);
        end
        checks++;
        if (bus_if.bus_addr_o !== 32'h0 || bus_if.bus_wdata_o !== 32'h0) begin
            errors++; $display("FAIL reset_addr_wdata got %h/%h want 0/0", bus_if.bus_addr_o, bus_if.bus_wdata_o);
        end
        checks++;
        if (stall_o !== 1'b0 || data_o !== din || bypass_reg_addr_mm !== 5'd17) begin
            errors++; $display("FAIL reset_comb got stall=%b data=%h byp=%0d want 0/%h/17",
                               stall_o, data_o, bypass_reg_addr_mm, din);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lb_signed();
        int st; logic ae, rd, wr, stb; logic [31:0] d, ba, wd; logic [3:0] be;
        run_txn(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_BYTE, 1'b1, 32'h1003, 32'h5555_5555, 0,
                32'h80FF_0000, st, ae, d, ba, be, wd, rd, wr, stb);
        checks++;
        if (st != 2) begin errors++; $display("FAIL lb_stalls got %0d want 2", st); end
        checks++;
        if (ba !== 32'h1000 || be !== 4'b0000 || rd !== 1'b1 || wr !== 1'b0) begin
            errors++; $display("FAIL lb_bus got addr=%h be=%b rd=%b wr=%b want 1000/0000/1/0", ba, be, rd, wr);
        end
        checks++;
        if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", d); end
    endtask

    task automatic test_sh_wait();
        int st; logic ae, rd, wr, stb; logic [31:0] d, ba, wd; logic [3:0] be;
        run_txn(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_HALF, 1'b0, 32'h2002, 32'h0000_BEEF, 3,
                32'h0, st, ae, d, ba, be, wd, rd, wr, stb);
        checks++;
        if (st != 5) begin errors++; $display("FAIL sh_stalls got %0d want 5", st); end
        checks++;
        if (be !== 4'b1100 || wd[31:16] !== 16'hBEEF || ba !== 32'h2000 || wr !== 1'b1) begin
            errors++; $display("FAIL sh_bus got be=%b wd=%h addr=%h wr=%b want 1100/beef..../2000/1", be, wd, ba, wr);
        end
        checks++;
        if (stb !== 1'b1) begin errors++; $display("FAIL sh_stable got %b want 1", stb); end
        checks++;
        if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL sh_data got %h want 0000beef", d); end
    endtask

    task automatic test_align_err();
        int st; logic ae, rd, wr, stb; logic [31:0] d, ba, wd; logic [3:0] be;
        run_txn(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h3001, 32'hCAFE_F00D, 0,
                32'h0, st, ae, d, ba, be, wd, rd, wr, stb);
        checks++;
        if (ae !== 1'b1 || st != 0 || d !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL lw_misaligned got err=%b stalls=%0d data=%h want 1/0/cafef00d", ae, st, d);
        end
        checks++;
        if (bus_if.bus_rd_o !== 1'b0) begin errors++; $display("FAIL lw_misaligned_rd got %b want 0", bus_if.bus_rd_o); end
        run_txn(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_LEFT_WORD, 1'b0, 32'h3001, 32'h0, 0,
                32'h0, st, ae, d, ba, be, wd, rd, wr, stb);
        checks++;
        if (ae !== 1'b0 || st != 2) begin
            errors++; $display("FAIL lwl_unaligned_ok got err=%b stalls=%0d want 0/2", ae, st);
        end
    endtask

    task automatic test_swl_lwr();
        int st; logic ae, rd, wr, stb; logic [31:0] d, ba, wd; logic [3:0] be;
        run_txn(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_LEFT_WORD, 1'b0, 32'h4001, 32'hAABB_CCDD, 1,
                32'h0, st, ae, d, ba, be, wd, rd, wr, stb);
        checks++;
        if (be !== 4'b0011 || wd[15:0] !== 16'hAABB) begin
            errors++; $display("FAIL swl_lanes got be=%b wd=%h want 0011/....aabb", be, wd);
        end
        run_txn(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_RIGHT_WORD, 1'b0, 32'h4002, 32'hAABB_CCDD, 0,
                32'h1122_3344, st, ae, d, ba, be, wd, rd, wr, stb);
        checks++;
        if (d !== 32'hAABB_1122) begin errors++; $display("FAIL lwr_merge got %h want aabb1122", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdv [6];
        logic [31:0] dv [6];
        logic [31:0] av [6];
        logic [5:0]  stall_seq;
        mem_access_type = MEM_ACCESS_TYPE_M2R; mem_access_size = MEM_ACCESS_LENGTH_WORD;
        mem_access_signed = 1'b0; mem_access_addr_i = 32'h5000; data_i = $urandom;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin mem_access_addr_i = 32'h5004; data_i = $urandom; end
            rdv[c] = $urandom;
            bus_if.bus_rdata_i = rdv[c];
            bus_if.bus_ready_i = 1'b1;
            @(negedge clk);
            stall_seq[c] = stall_o; dv[c] = data_o; av[c] = bus_if.bus_addr_o;
            @(posedge clk); #1;
        end
        mem_access_type = MEM_ACCESS_TYPE_NONE; bus_if.bus_ready_i = 1'b0;
        checks++;
        if (stall_seq !== 6'b011011) begin errors++; $display("FAIL b2b_stall_seq got %b want 011011", stall_seq); end
        checks++;
        if (dv[2] !== rdv[1] || dv[5] !== rdv[4]) begin
            errors++; $display("FAIL b2b_data got %h/%h want %h/%h", dv[2], dv[5], rdv[1], rdv[4]);
        end
        checks++;
        if (av[1] !== 32'h5000 || av[4] !== 32'h5004) begin
            errors++; $display("FAIL b2b_addr got %h/%h want 5000/5004", av[1], av[4]);
        end
    endtask

    task automatic test_random();
        int st, wn; logic ae, rd, wr, stb, sg, isreq, ae_exp;
        logic [31:0] d, ba, wd, ad, din, rdat, d_exp, wd_exp, mask;
        logic [3:0] be, be_exp;
        logic [1:0] ty; logic [2:0] sz;
        for (int n = 0; n < 60; n++) begin
            ty   = 2'($urandom_range(0, 3));
            sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            sg   = 1'($urandom);
            ad   = $urandom; din = $urandom; rdat = $urandom;
            wn   = $urandom_range(0, 3);
            run_txn(ty, sz, sg, ad, din, wn, rdat, st, ae, d, ba, be, wd, rd, wr, stb);
            ae_exp = (ty == MEM_ACCESS_TYPE_M2R || ty == MEM_ACCESS_TYPE_R2M) && m_misaligned(sz, ad[1:0]);
            isreq  = (ty == MEM_ACCESS_TYPE_M2R || ty == MEM_ACCESS_TYPE_R2M) && !ae_exp;
            d_exp  = (isreq && ty == MEM_ACCESS_TYPE_M2R) ? m_load(sz, sg, ad[1:0], rdat, din) : din;
            checks++;
            if (ae !== ae_exp || st != (isreq ? wn + 2 : 0)) begin
                errors++; $display("FAIL rnd%0d_ctrl got err=%b stalls=%0d want %b/%0d", n, ae, st, ae_exp, isreq ? wn + 2 : 0);
            end
            checks++;
            if (d !== d_exp) begin
                errors++; $display("FAIL rnd%0d_data ty=%0d sz=%0d a=%h got %h want %h", n, ty, sz, ad, d, d_exp);
            end
            if (isreq) begin
                checks++;
                if (ba !== {ad[31:2], 2'b00} || rd !== (ty == MEM_ACCESS_TYPE_M2R) ||
                    wr !== (ty == MEM_ACCESS_TYPE_R2M) || stb !== 1'b1) begin
                    errors++; $display("FAIL rnd%0d_bus got addr=%h rd=%b wr=%b stable=%b", n, ba, rd, wr, stb);
                end
                if (ty == MEM_ACCESS_TYPE_R2M) begin
                    m_store(sz, ad[1:0], din, be_exp, wd_exp);
                    mask = '0;
                    for (int i = 0; i < 4; i++) if (be_exp[i]) mask[8*i +: 8] = 8'hFF;
                    checks++;
                    if (be !== be_exp || (wd & mask) !== wd_exp) begin
                        errors++; $display("FAIL rnd%0d_store sz=%0d a=%0d got be=%b wd=%h want be=%b wd=%h",
                                           n, sz, ad[1:0], be, wd & mask, be_exp, wd_exp);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int st; logic ae, rd, wr, stb; logic [31:0] d, ba, wd; logic [3:0] be;
        mem_access_type = MEM_ACCESS_TYPE_M2R; mem_access_size = MEM_ACCESS_LENGTH_WORD;
        mem_access_addr_i = 32'h6000; bus_if.bus_ready_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus_if.bus_rd_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_rd got %b want 1", bus_if.bus_rd_o); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.bus_rd_o !== 1'b0) begin errors++; $display("FAIL rst_mid_async_rd got %b want 0", bus_if.bus_rd_o); end
        mem_access_type = MEM_ACCESS_TYPE_NONE;
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0 || bus_if.bus_rd_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got stall=%b rd=%b want 0/0", stall_o, bus_if.bus_rd_o);
        end
        @(posedge clk); #1;
        run_txn(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h6004, 32'h0, 1,
                32'h0BAD_BEEF, st, ae, d, ba, be, wd, rd, wr, stb);
        checks++;
        if (st != 3 || d !== 32'h0BAD_BEEF) begin
            errors++; $display("FAIL rst_mid_after got stalls=%0d data=%h want 3/0badbeef", st, d);
        end
    endtask

`ifdef MM_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int n, pulses; logic [31:0] d;
        n = 0; pulses = 0;
        mem_access_type = MEM_ACCESS_TYPE_M2R; mem_access_size = MEM_ACCESS_LENGTH_WORD;
        mem_access_addr_i = 32'h7000; data_i = 32'h7777_7777; bus_if.bus_ready_i = 1'b0;
        @(negedge clk);
        while (stall_o === 1'b1 && n < 30) begin
            n++;
            if (bus_if.bus_err_o === 1'b1) pulses++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        if (bus_if.bus_err_o === 1'b1) pulses++;
        d = data_o;
        @(posedge clk); #1;
        mem_access_type = MEM_ACCESS_TYPE_NONE;
        repeat (5) begin @(negedge clk); if (bus_if.bus_err_o === 1'b1) pulses++; end
        checks++;
        if (n != int'(TO) + 1) begin errors++; $display("FAIL timeout_stalls got %0d want %0d", n, TO + 1); end
        checks++;
        if (pulses != 1 || d !== 32'h0) begin
            errors++; $display("FAIL timeout_err got pulses=%0d data=%h want 1/0", pulses, d);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_lb_signed();
        test_sh_wait();
        test_align_err();
        test_swl_lwr();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
`ifdef MM_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
